// File: rtl/seg7_bcd_display_if.sv
// Handshake and result bundle between a requester and a seg7_bcd_display
// instance. The requester drives start/bin; the converter returns status,
// BCD digits, overflow flag and active-low segment patterns.
interface seg7_bcd_display_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ovf;
   logic [7*DIGITS-1:0]   seg;

   modport master (
      output start, bin,
      input  busy, done, bcd, ovf, seg
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd, ovf, seg
   );
endinterface

// File: rtl/seg7_bcd_display.sv
// Sequential binary-to-7-segment driver. A double-dabble engine consumes one
// input bit per clock; the final scratch is turned into BCD digits, an
// overflow flag and active-low {g..a} segment patterns with optional
// leading-zero blanking. All results are registered and held until the next
// conversion completes.
module seg7_bcd_display #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 1
) (
   input  logic                clk,
   input  logic                rst,
   seg7_bcd_display_if.slave   bus
);

   // Scratch nibbles needed to hold any WIDTH-bit value in BCD.
   localparam int NIB = (WIDTH + 2) / 3 + 1;
   localparam int CW  = $clog2(WIDTH + 1);

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01
   } state_t;

   state_t                state_reg;
   state_t                state_next;
   logic                  load;
   logic                  step;
   logic                  finish;

   logic [WIDTH-1:0]      shift_reg;
   logic [4*NIB-1:0]      scratch_reg;
   logic [4*NIB-1:0]      adj;
   logic [4*NIB:0]        scratch_full;
   logic [CW-1:0]         cnt_reg;

   logic                  done_reg;
   logic                  ovf_reg;
   logic [4*DIGITS-1:0]   bcd_reg;
   logic [7*DIGITS-1:0]   seg_reg;

   logic                  ovf_calc;
   logic [4*DIGITS-1:0]   bcd_calc;
   logic [7*DIGITS-1:0]   seg_calc;
   logic [3:0]            dig [DIGITS];
   logic [DIGITS-1:0]     lz_blank;
   logic                  lz_nz;

   // Decimal digit to active-low gfedcba pattern.
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction on every scratch nibble that would overflow when doubled.
   generate
      for (genvar gi = 0; gi < NIB; gi++) begin : g_adj
         assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                 ? scratch_reg[4*gi +: 4] + 4'd3
                                 : scratch_reg[4*gi +: 4];
      end
   endgenerate

   // Shifted scratch; the extra top bit is always zero for a correctly sized
   // scratch but is folded into the overflow flag so nothing is left dangling.
   assign scratch_full = {adj, shift_reg[WIDTH-1]};

   // Displayed digits come from the low scratch nibbles, zero-padded when the
   // display is wider than the scratch.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
         if (gi < NIB) begin : g_src
            assign dig[gi] = scratch_full[4*gi +: 4];
         end else begin : g_pad
            assign dig[gi] = 4'd0;
         end
         assign bcd_calc[4*gi +: 4] = dig[gi];
         assign seg_calc[7*gi +: 7] = ovf_calc      ? SEG_DASH  :
                                      lz_blank[gi]  ? SEG_BLANK :
                                                      seg_of(dig[gi]);
      end

      if (NIB > DIGITS) begin : g_ovf
         assign ovf_calc = |scratch_full[4*NIB:4*DIGITS];
      end else begin : g_no_ovf
         assign ovf_calc = scratch_full[4*NIB];
      end
   endgenerate

   // Blank each digit above the most significant nonzero one; units never blank.
   always_comb begin
      lz_blank = '0;
      lz_nz    = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (dig[i] != 4'd0) begin
            lz_nz = 1'b1;
         end
         lz_blank[i] = (BLANK_LZ != 0) && (i != 0) && !lz_nz;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state and datapath strobes.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt_reg == CW'(1)) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Conversion engine and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg   <= '0;
         scratch_reg <= '0;
         cnt_reg     <= '0;
         done_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         bcd_reg     <= '0;
         seg_reg     <= '1;
      end else begin
         done_reg <= finish;
         if (load) begin
            shift_reg   <= bus.bin;
            scratch_reg <= '0;
            cnt_reg     <= CW'(WIDTH);
         end
         if (step) begin
            shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
            scratch_reg <= scratch_full[4*NIB-1:0];
            cnt_reg     <= cnt_reg - CW'(1);
         end
         if (finish) begin
            bcd_reg <= bcd_calc;
            ovf_reg <= ovf_calc;
            seg_reg <= seg_calc;
         end
      end
   end

   assign bus.busy = (state_reg == SHIFT);
   assign bus.done = done_reg;
   assign bus.bcd  = bcd_reg;
   assign bus.ovf  = ovf_reg;
   assign bus.seg  = seg_reg;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Directed bench for seg7_bcd_display: three instances (default, no blanking,
// two digits) share clock and reset; each conversion is checked for latency,
// single-cycle done, BCD, overflow and segment patterns.
module tb_seg7_bcd_display;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_bcd_display_if #(.WIDTH(8), .DIGITS(3)) if_def ();
   seg7_bcd_display_if #(.WIDTH(8), .DIGITS(3)) if_nlz ();
   seg7_bcd_display_if #(.WIDTH(8), .DIGITS(2)) if_d2 ();

   seg7_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u_def (
      .clk (clk), .rst (rst), .bus (if_def));
   seg7_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) u_nlz (
      .clk (clk), .rst (rst), .bus (if_nlz));
   seg7_bcd_display #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1)) u_d2 (
      .clk (clk), .rst (rst), .bus (if_d2));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic [7:0] v);
      case (sel)
         0:       begin if_def.start = s; if_def.bin = v; end
         1:       begin if_nlz.start = s; if_nlz.bin = v; end
         default: begin if_d2.start  = s; if_d2.bin  = v; end
      endcase
   endtask

   function automatic logic get_done(input int sel);
      case (sel)
         0:       return if_def.done;
         1:       return if_nlz.done;
         default: return if_d2.done;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return if_def.busy;
         1:       return if_nlz.busy;
         default: return if_d2.busy;
      endcase
   endfunction

   function automatic logic [63:0] get_bcd(input int sel);
      case (sel)
         0:       return 64'(if_def.bcd);
         1:       return 64'(if_nlz.bcd);
         default: return 64'(if_d2.bcd);
      endcase
   endfunction

   function automatic logic [63:0] get_seg(input int sel);
      case (sel)
         0:       return 64'(if_def.seg);
         1:       return 64'(if_nlz.seg);
         default: return 64'(if_d2.seg);
      endcase
   endfunction

   function automatic logic get_ovf(input int sel);
      case (sel)
         0:       return if_def.ovf;
         1:       return if_nlz.ovf;
         default: return if_d2.ovf;
      endcase
   endfunction

   // One conversion: start for one edge, then wait (bounded) for done.
   // Called at posedge+1; returns at posedge+1 with results still held.
   task automatic convert(input int sel, input logic [7:0] v);
      int lat;
      drive(sel, 1'b1, v);
      @(posedge clk); #1;
      drive(sel, 1'b0, v);
      chk("busy_after_start", 64'(get_busy(sel)), 64'd1);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (get_done(sel)) begin
            lat = k;
            break;
         end
      end
      chk("done_latency", 64'(lat), 64'd8);
      chk("busy_in_done_cycle", 64'(get_busy(sel)), 64'd0);
      $display("[TB] dut=%0d bin=%0d latency=%0d bcd=%0h ovf=%0b seg=%b",
               sel, v, lat, get_bcd(sel), get_ovf(sel), get_seg(sel));
      @(posedge clk); #1;
      chk("done_single_pulse", 64'(get_done(sel)), 64'd0);
   endtask

   initial begin
      int         ndone;
      int         first_k;
      int         second_k;
      logic [63:0] b1;
      logic [63:0] b2;
      logic [63:0] b3;
      logic       got;

      drive(0, 1'b0, 8'd0);
      drive(1, 1'b0, 8'd0);
      drive(2, 1'b0, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_seg_def", get_seg(0), 64'h1FFFFF);
      chk("rst_seg_d2", get_seg(2), 64'h3FFF);
      chk("rst_bcd", get_bcd(0), 64'h0);
      chk("rst_busy", 64'(get_busy(0)), 64'd0);
      chk("rst_done", 64'(get_done(0)), 64'd0);
      chk("rst_ovf", 64'(get_ovf(2)), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      convert(0, 8'd0);
      chk("zero_bcd", get_bcd(0), 64'h000);
      chk("zero_seg", get_seg(0), 64'({SB, SB, S0}));

      convert(0, 8'd255);
      chk("max_bcd", get_bcd(0), 64'h255);
      chk("max_seg", get_seg(0), 64'({S2, S5, S5}));
      chk("max_ovf", 64'(get_ovf(0)), 64'd0);

      convert(0, 8'd100);
      chk("inner_zero_bcd", get_bcd(0), 64'h100);
      chk("inner_zero_seg", get_seg(0), 64'({S1, S0, S0}));

      convert(1, 8'd7);
      chk("nlz_bcd", get_bcd(1), 64'h007);
      chk("nlz_seg", get_seg(1), 64'({S0, S0, S7}));

      convert(2, 8'd150);
      chk("ovf_flag", 64'(get_ovf(2)), 64'd1);
      chk("ovf_seg", get_seg(2), 64'({SD, SD}));
      chk("ovf_bcd", get_bcd(2), 64'h50);

      convert(2, 8'd99);
      chk("d2_ovf", 64'(get_ovf(2)), 64'd0);
      chk("d2_bcd", get_bcd(2), 64'h99);
      chk("d2_seg", get_seg(2), 64'({S9, S9}));

      repeat (5) @(posedge clk);
      #1;
      chk("hold_bcd", get_bcd(2), 64'h99);

      // start held high with bin changing every cycle
      ndone    = 0;
      first_k  = -1;
      second_k = -1;
      b1       = '0;
      b2       = '0;
      for (int k = 0; k < 20; k++) begin
         drive(0, 1'b1, 8'(10 + 7 * k));
         @(posedge clk); #1;
         if (get_done(0)) begin
            ndone++;
            if (ndone == 1) begin
               first_k = k;
               b1      = get_bcd(0);
            end else if (ndone == 2) begin
               second_k = k;
               b2       = get_bcd(0);
            end
            $display("[TB] held edge=%0d bcd=%0h", k, get_bcd(0));
         end
      end
      drive(0, 1'b0, 8'd0);
      chk("held_done_count", 64'(ndone), 64'd2);
      chk("held_first_edge", 64'(first_k), 64'd8);
      chk("held_second_edge", 64'(second_k), 64'd17);
      chk("held_first_bcd", b1, 64'h010);
      chk("held_second_bcd", b2, 64'h073);
      got = 1'b0;
      b3  = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (get_done(0)) begin
            got = 1'b1;
            b3  = get_bcd(0);
            break;
         end
      end
      chk("held_third_done", 64'(got), 64'd1);
      chk("held_third_bcd", b3, 64'h136);
      @(posedge clk); #1;

      // reset in the middle of a conversion
      drive(0, 1'b1, 8'd255);
      @(posedge clk); #1;
      drive(0, 1'b0, 8'd0);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_bcd", get_bcd(0), 64'h000);
      chk("midrst_seg", get_seg(0), 64'h1FFFFF);
      chk("midrst_busy", 64'(get_busy(0)), 64'd0);
      chk("midrst_done", 64'(get_done(0)), 64'd0);
      chk("midrst_ovf", 64'(get_ovf(0)), 64'd0);
      @(posedge clk); #1;
      rst   = 1'b0;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (get_done(0)) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);
      $display("[TB] reset aborted conversion, done pulses afterwards=%0d", ndone);

      convert(0, 8'd42);
      chk("after_rst_bcd", get_bcd(0), 64'h042);
      chk("after_rst_seg", get_seg(0), 64'({SB, S4, S2}));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
